// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmit path.
//   tx_state_t : transmitter FSM states
//   tx_frame_t : latched command byte plus its odd-parity bit
//   CMD_*      : common keyboard command bytes
//   odd_parity : parity bit that makes the 9-bit data+parity word odd
//   frame_bit  : bit value sent for a given bit index (data, parity, stop)
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } tx_state_t;

    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } tx_frame_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    localparam int unsigned BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] PARITY_IDX = BIT_CNT_W'(8);
    localparam logic [BIT_CNT_W-1:0] STOP_IDX   = BIT_CNT_W'(9);

    // Complement of the XOR of the byte: total ones in data+parity is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Index 0..7 are data bits LSB first, 8 is parity, 9 and above the stop bit (1).
    function automatic logic frame_bit(input tx_frame_t f, input logic [BIT_CNT_W-1:0] idx);
        logic b;
        if (idx < PARITY_IDX) begin
            b = f.data[idx[2:0]];
        end else if (idx == PARITY_IDX) begin
            b = f.parity;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Multi-stage synchroniser for one asynchronous PS/2 line, with a
// registered falling-edge flag. Shared by the transmitter and receiver.
//   clk, rst_n : system clock, synchronous active-low reset
//   din        : raw line level (asynchronous)
//   level      : synchronised line level
//   fall       : high for one cycle, in the first cycle level reads 0 after 1
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    // sync_q[0] is the newest sample; SYNC_STAGES must be at least 2.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fall_q;

    // Idle PS/2 lines are pulled high, so the chain resets to 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            // Looks one stage ahead so the flag lines up with level dropping.
            fall_q <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// with the device-generated clock and reports ACK, no-ACK or timeout.
//   clk, rst_n       : system clock, synchronous active-low reset
//   tx_data/tx_valid : command byte and send request
//   tx_ready         : idle and able to accept a byte
//   ps2_clk_in       : raw PS/2 clock line (asynchronous)
//   ps2_data_in      : raw PS/2 data line (asynchronous)
//   ps2_clk_oe       : 1 pulls the clock line low
//   ps2_data_oe      : 1 pulls the data line low
//   done             : one-cycle pulse on ACKed completion
//   err, err_timeout : one-cycle error pulse; err_timeout 1 = timeout, 0 = no-ACK
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       err,
    output logic       err_timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    tx_state_t              state_q,   state_d;
    tx_frame_t              frame_q,   frame_d;
    logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]        to_cnt_q,  to_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   clk_oe_q,  clk_oe_d;
    logic                   data_oe_q, data_oe_d;
    logic                   ready_q,   ready_d;
    logic                   done_q,    done_d;
    logic                   err_q,     err_d;
    logic                   err_to_q,  err_to_d;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;
    logic to_hit;

    // Line synchronisers; only the clock line's edge flag is needed here.
    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    assign to_hit = (to_cnt_q == TO_LAST);

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_to_q  <= err_to_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ready_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_to_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                // ready rises one cycle after entering IDLE, i.e. after the pulse.
                ready_d   = 1'b1;
                if (tx_valid && ready_q) begin
                    frame_d.data   = tx_data;
                    frame_d.parity = odd_parity(tx_data);
                    inh_cnt_d      = '0;
                    clk_oe_d       = 1'b1;
                    ready_d        = 1'b0;
                    state_d        = INHIBIT;
                end
            end

            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    // Start bit goes low while the clock is still held.
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end

            REQ: begin
                clk_oe_d  = 1'b0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end

            SEND, ACK, WAIT_IDLE: begin
                if (to_hit) begin
                    // Timeout has priority over any edge in the same cycle.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    err_to_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_W'(1);
                    case (state_q)
                        SEND: begin
                            if (clk_fall) begin
                                data_oe_d = ~frame_bit(frame_q, bit_cnt_q);
                                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                                if (bit_cnt_q == STOP_IDX) begin
                                    state_d = ACK;
                                end
                            end
                        end
                        ACK: begin
                            if (clk_fall) begin
                                if (data_level) begin
                                    err_d   = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    state_d = WAIT_IDLE;
                                end
                            end
                        end
                        default: begin
                            // Device must release both lines before completion.
                            if (clk_level && data_level) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    endcase
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_timeout = err_to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// and a scoreboard checks each done/err pulse against queued expectations.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 5000;
    localparam int unsigned TO   = 1500;
    localparam int unsigned HALF = 20;
    localparam int unsigned INH2 = 4;
    localparam int unsigned TO2  = 45;
    localparam int LIMIT = 20000;

    typedef enum {EV_DONE, EV_NOACK, EV_TIMEOUT} ev_t;
    typedef struct { ev_t kind; int lat; } exp_t;
    typedef struct { int edges; bit ack; logic [9:0] frame; int half; } dev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    longint cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Main DUT
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready, clk_oe, data_oe, done, err, err_to;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic clk_in, data_in;
    assign clk_in  = dev_clk & ~clk_oe;
    assign data_in = dev_data & ~data_oe;

    // Small-timeout DUT for the timeout/edge collision
    logic [7:0] tx_data2 = 8'h00;
    logic tx_valid2 = 1'b0;
    logic tx_ready2, clk_oe2, data_oe2, done2, err2, err_to2;
    logic dev_clk2 = 1'b1, dev_data2 = 1'b1;
    logic clk_in2, data_in2;
    assign clk_in2  = dev_clk2 & ~clk_oe2;
    assign data_in2 = dev_data2 & ~data_oe2;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    dev_t dev_q[$];
    bit dev_busy = 1'b0;
    int dev_done = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(clk_in), .ps2_data_in(data_in), .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe),
        .done(done), .err(err), .err_timeout(err_to));

    ps2_host_tx #(.INHIBIT_CYCLES(INH2), .TIMEOUT_CYCLES(TO2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .ps2_clk_in(clk_in2), .ps2_data_in(data_in2), .ps2_clk_oe(clk_oe2), .ps2_data_oe(data_oe2),
        .done(done2), .err(err2), .err_timeout(err_to2));

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Frame as the device sees it: 8 data bits LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = (($countones(b) % 2) == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    function automatic logic [2:0] pulse_code(input ev_t k);
        case (k)
            EV_DONE:  return 3'b100;
            EV_NOACK: return 3'b010;
            default:  return 3'b011;
        endcase
    endfunction

    // Scoreboard monitor, main DUT
    initial begin : mon1
        bit prev_oe, pend_ready;
        int inh_run, req_run;
        longint rel_cyc;
        exp_t e;
        prev_oe = 0; pend_ready = 0; inh_run = 0; req_run = 0; rel_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_oe = 0; pend_ready = 0; inh_run = 0; req_run = 0;
            end else begin
                if (pend_ready) begin
                    chk("ready_after_pulse", tx_ready, 1);
                    pend_ready = 0;
                end
                if (clk_oe && !data_oe) inh_run++;
                if (clk_oe && data_oe) req_run++;
                if (prev_oe && !clk_oe && data_oe) begin
                    rel_cyc = cyc;
                    chk("inhibit_len", inh_run, INH);
                    chk("req_len", req_run, 1);
                    inh_run = 0; req_run = 0;
                end
                prev_oe = clk_oe;
                if (done || err) begin
                    pend_ready = 1;
                    chk("lines_released", {clk_oe, data_oe}, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {done, err, err_to}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_kind", {done, err, err_to}, pulse_code(e.kind));
                        if (e.lat > 0) chk("timeout_latency", cyc - rel_cyc, e.lat);
                        if (e.kind == EV_DONE) chk("lines_idle_at_done", {clk_in, data_in}, 2'b11);
                    end
                end
            end
        end
    end

    // Scoreboard monitor, small-timeout DUT
    initial begin : mon2
        bit prev_oe;
        longint rel_cyc;
        exp_t e;
        prev_oe = 0; rel_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_oe = 0;
            end else begin
                if (prev_oe && !clk_oe2 && data_oe2) rel_cyc = cyc;
                prev_oe = clk_oe2;
                if (done2 || err2) begin
                    chk("dut2_lines_released", {clk_oe2, data_oe2}, 0);
                    if (exp2_q.size() == 0) begin
                        chk("dut2_unexpected_pulse", {done2, err2, err_to2}, 0);
                    end else begin
                        e = exp2_q.pop_front();
                        chk("dut2_pulse_kind", {done2, err2, err_to2}, pulse_code(e.kind));
                        chk("dut2_timeout_latency", cyc - rel_cyc, e.lat);
                    end
                end
            end
        end
    end

    // PS/2 device model: clocks the frame out of the host, optionally ACKs
    initial begin : device
        dev_t d;
        int n;
        logic [9:0] got;
        forever begin
            @(negedge clk);
            if (dev_q.size() > 0) begin
                d = dev_q.pop_front();
                dev_busy = 1'b1;
                n = 0;
                while (!(clk_in === 1'b1 && data_in === 1'b0) && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                chk("device_request_seen", n < LIMIT, 1);
                got = '0;
                for (int e = 1; e <= d.edges; e++) begin
                    if (e == 11 && d.ack) dev_data = 1'b0;
                    repeat (d.half) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (d.half) @(negedge clk);
                    if (e <= 10) got[e-1] = data_in;
                    dev_clk = 1'b1;
                end
                repeat (d.half) @(negedge clk);
                dev_data = 1'b1;
                if (d.edges >= 10) chk("frame_bits", got, d.frame);
                dev_busy = 1'b0;
                dev_done++;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_drops_after_accept", tx_ready, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || dev_q.size() != 0 || dev_busy) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("transfer_finished", n < LIMIT, 1);
        repeat (5) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] b, input ev_t k, input int edges, input bit ack, input int half);
        exp_q.push_back('{kind: k, lat: (k == EV_TIMEOUT) ? int'(TO) : 0});
        dev_q.push_back('{edges: edges, ack: ack, frame: frame_of(b), half: half});
        send(b);
        wait_idle();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int target;
        logic [7:0] rb;
        bit rack;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_pulses", {done, err, err_to}, 0);
        chk("rst_dut2_ready", tx_ready2, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset while in SEND after 4 falling edges of 0xA5
        target = dev_done + 1;
        dev_q.push_back('{edges: 4, ack: 1'b0, frame: '0, half: HALF});
        send(8'hA5);
        n = 0;
        while (dev_done < target && n < LIMIT) begin @(negedge clk); n++; end
        chk("mid_send_device_done", n < LIMIT, 1);
        chk("mid_send_bit3_driven", data_oe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_clk_oe", clk_oe, 0);
        chk("mid_rst_data_oe", data_oe, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_pulses", {done, err}, 0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);

        // Directed transfers
        xfer(CMD_SET_LED, EV_DONE, 11, 1'b1, HALF);
        xfer(8'h00, EV_NOACK, 11, 1'b0, HALF);
        xfer(CMD_ENABLE, EV_TIMEOUT, 3, 1'b0, HALF);

        // tx_valid held high across two back-to-back commands
        exp_q.push_back('{kind: EV_DONE, lat: 0});
        exp_q.push_back('{kind: EV_DONE, lat: 0});
        dev_q.push_back('{edges: 11, ack: 1'b1, frame: frame_of(CMD_RESET), half: HALF});
        dev_q.push_back('{edges: 11, ack: 1'b1, frame: frame_of(CMD_ENABLE), half: HALF});
        @(negedge clk);
        tx_data = CMD_RESET;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("b2b_first_accept", tx_ready, 0);
        tx_data = CMD_ENABLE;
        n = 0;
        while (!tx_ready && n < LIMIT) begin @(negedge clk); n++; end
        chk("b2b_ready_returns", tx_ready, 1);
        @(negedge clk);
        chk("b2b_ready_one_cycle", tx_ready, 0);
        tx_valid = 1'b0;
        wait_idle();

        // Randomised transfers
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            rack = 1'($urandom_range(0, 1));
            xfer(rb, rack ? EV_DONE : EV_NOACK, 11, rack, int'($urandom_range(15, 30)));
        end

        // Small-timeout DUT: ACK falling edge lands on the last timeout count
        exp2_q.push_back('{kind: EV_TIMEOUT, lat: int'(TO2)});
        @(negedge clk);
        tx_data2 = CMD_RESET;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        n = 0;
        while (!(clk_oe2 === 1'b0 && data_oe2 === 1'b1) && n < 100) begin @(negedge clk); n++; end
        chk("dut2_release_seen", n < 100, 1);
        // Line change at negedge c shows as a falling-edge flag in cycle c+2.
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 38 && ((c - 2) % 4) == 0) dev_clk2 = 1'b0;
            if (c >= 4 && c <= 40 && ((c - 4) % 4) == 0) dev_clk2 = 1'b1;
            if (c == 40) dev_data2 = 1'b0;
            if (c == int'(TO2) - 3) dev_clk2 = 1'b0;
            if (c == int'(TO2) + 1) begin dev_clk2 = 1'b1; dev_data2 = 1'b1; end
        end
        chk("dut2_events_consumed", exp2_q.size(), 0);
        chk("main_events_consumed", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- It is the opposite direction of the keyboard scan-code receive path that feeds note decode and comparison in the piano.
- It drives open-collector enables for the PS/2 clock and data lines, follows the device-generated clock, and reports ACK, no-ACK or timeout.

Parameters:
- INHIBIT_CYCLES, 5000, system clocks the PS/2 clock is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, maximum system clocks from clock release to ACK completion (20 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages that synchronise ps2_clk_in and ps2_data_in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high when IDLE and a new byte can be accepted.
- ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line level (asynchronous).
- ps2_clk_oe  out  1  1 pulls the PS/2 clock line low; 0 releases it.
- ps2_data_oe  out  1  1 pulls the PS/2 data line low; 0 releases it.
- done  out  1  one-cycle pulse when a transfer completes with ACK.
- err  out  1  one-cycle pulse on no-ACK or timeout.
- err_timeout  out  1  valid with err: 1 = timeout, 0 = no-ACK.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State = IDLE; tx_ready = 1.
  - ps2_clk_oe = 0, ps2_data_oe = 0.
  - done = err = err_timeout = 0; all counters cleared.
  - Reset applied mid-transfer aborts the transfer, releases both lines on the next edge and emits no pulse.
- Accept: tx_valid && tx_ready at a clk edge latches tx_data.
  - Odd parity is computed as the complement of the XOR of the 8 bits.
  - tx_ready drops in the next cycle.
  - tx_valid while busy is ignored.
- Falling-edge detect: the synchronised clock is 1 in the previous cycle and 0 in the current cycle.
- IDLE: both enables 0. On accept, go to INHIBIT.
- INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ, one cycle:
  - Set ps2_data_oe = 1 (start bit 0) while ps2_clk_oe is still 1.
  - Next cycle: ps2_clk_oe = 0, clear the timeout counter, clear bit_cnt, go to SEND.
- SEND: on each falling edge, drive the next bit. For a bit value b, ps2_data_oe = ~b.
  - bit_cnt 0..7: data bits, LSB first.
  - bit_cnt 8: parity.
  - bit_cnt 9: stop bit (release, ps2_data_oe = 0), then go to ACK.
- ACK: on the next falling edge, sample the synchronised data.
  - 0: go to WAIT_IDLE.
  - 1: pulse err with err_timeout = 0, then go to IDLE.
- WAIT_IDLE: when synchronised clock and data are both 1, pulse done and go to IDLE.
- Timeout:
  - The counter runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES-1: release both lines, pulse err with err_timeout = 1, go to IDLE.
  - If a timeout and an edge occur in the same cycle, the timeout wins.
- Return to IDLE: tx_ready = 1 in the cycle after the done/err pulse, so a back-to-back accept is legal.
- Widths:
  - bit_cnt is 4 bits.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.
  - The inhibit counter is $clog2(INHIBIT_CYCLES+1) bits.
- Outputs are registered. There is no combinational path from input lines to the enables.

Decomposition:
- Package ps2_pkg:
  - enum tx_state_t {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE}.
  - Command constants: CMD_SET_LED = 8'hED, CMD_RESET = 8'hFF, CMD_ENABLE = 8'hF4.
  - Function odd_parity(logic [7:0]).
- Sub-module ps2_sync_edge, instanced twice (clock and data): SYNC_STAGES synchroniser plus a registered falling-edge output. The receiver reuses it.

Test Plan:
- Reset mid-SEND (after 4 falling edges) -> next cycle both enables 0, tx_ready = 1, no done/err pulse.
- Send 0xED; device model clocks 11 falling edges at 12 kHz and drives ACK low -> clk_oe high for 5000 cycles.
  - Data line sequence: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once after both lines are high; err never asserts.
- Send 0x00; device never drives ACK -> parity bit = 1, err pulses with err_timeout = 0, tx_ready = 1 next cycle.
- Send 0xF4; device stops clocking after 3 edges -> err with err_timeout = 1 exactly TIMEOUT_CYCLES cycles after clock release; both enables 0.
- tx_valid held high with 0xFF then 0xF4 -> first byte accepted; tx_valid during busy is ignored; second byte accepted in the cycle tx_ready returns; two done pulses in order.
- Timeout count reaching TIMEOUT_CYCLES-1 in the same cycle as the ACK falling edge (use a small TIMEOUT_CYCLES) -> err with err_timeout = 1; done not pulsed.
